// File: rtl/w_bit_n_demux_pkg.sv
// w_bit_n_demux_pkg: shared defaults and slot-state encoding for the demux.
package w_bit_n_demux_pkg;
  localparam int DEF_N = 4;
  localparam int DEF_M = 2;
  localparam int DEF_W = 4;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;
endpackage

// File: rtl/w_bit_n_demux_out_slot.sv
// demux_out_slot: one-entry output slot with a W-bit register and a full flag.
module demux_out_slot
  import w_bit_n_demux_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  slot_state_t  r_state;
  logic [W-1:0] r_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
    end else if (i_load) begin
      r_state <= FULL;
      r_data  <= i_data;
    end else if (r_state == FULL && i_ready) begin
      r_state <= EMPTY;
    end
  end
  assign o_valid = (r_state == FULL);
  assign o_data  = r_data;
endmodule

// File: rtl/w_bit_n_demux.sv
// w_bit_n_demux: routes a W-bit word to one of N one-entry output slots, dropping out-of-range selects.
module w_bit_n_demux
  import w_bit_n_demux_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int m = DEF_M,
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic [m-1:0]   sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*W-1:0] out,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic [7:0]     drop_cnt
);
  localparam int P = 1 << m;
  localparam logic [m:0] NL = (m+1)'(N);
  logic [P-1:0] w_full_p;
  logic [P-1:0] w_rdy_p;
  logic         w_oor;
  logic         w_take;
  logic [7:0]   r_drop;
  // widen per-channel flags to the full select range so sel never indexes past the vector
  assign w_full_p = P'(out_valid);
  assign w_rdy_p  = P'(out_ready);
  assign w_oor    = {1'b0, sel} >= NL;
  assign in_ready = w_oor | ~w_full_p[sel] | w_rdy_p[sel];
  assign w_take   = in_valid & in_ready & ~rst;
  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_out_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_take && sel == m'(k)),
      .i_data  (in_data),
      .i_ready (out_ready[k]),
      .o_valid (out_valid[k]),
      .o_data  (out[k*W +: W])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) r_drop <= '0;
    else if (w_take && w_oor && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
  end
  assign drop_cnt = r_drop;
endmodule

// File: tb/tb_w_bit_n_demux.sv
// tb_w_bit_n_demux: scoreboard bench for the demux (N=4 main instance, N=3 out-of-range instance).
module tb_w_bit_n_demux;
  localparam int N = 4;
  localparam int M = 2;
  localparam int W = 4;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   in_data = '0;
  logic [M-1:0]   sel = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] out;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '1;
  logic [7:0]     drop_cnt;
  logic [W-1:0]   data3 = '0;
  logic [M-1:0]   sel3 = '0;
  logic           in_valid3 = 1'b0;
  logic           in_ready3;
  logic [3*W-1:0] out3;
  logic [2:0]     out_valid3;
  logic [2:0]     out_ready3 = '1;
  logic [7:0]     drop_cnt3;
  logic [W-1:0]   q [N][$];
  int total = 0;
  int bad = 0;

  w_bit_n_demux #(.N(N), .m(M), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  w_bit_n_demux #(.N(3), .m(M), .W(W)) dut3 (
    .clk(clk), .rst(rst), .in_data(data3), .sel(sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out(out3), .out_valid(out_valid3), .out_ready(out_ready3),
    .drop_cnt(drop_cnt3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: at each falling edge predict this cycle's transfers from the queues
  always @(negedge clk) begin
    for (int k = 0; k < N; k++)
      chk($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(q[k].size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q[sel].size() == 0 || out_ready[sel]));
    if (rst) begin
      for (int k = 0; k < N; k++) q[k].delete();
    end else begin
      for (int k = 0; k < N; k++)
        if (out_valid[k] && out_ready[k]) begin
          if (q[k].size() == 0) chk($sformatf("pop_empty%0d", k), 32'd1, 32'd0);
          else chk($sformatf("ch%0d_data", k), 32'(out[k*W +: W]), 32'(q[k].pop_front()));
        end
      if (in_valid && in_ready) q[sel].push_back(in_data);
    end
  end

  initial begin
    int n;
    repeat (2) step();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();
    // single word, consumer ready
    in_valid = 1'b1; sel = 2'd0; in_data = 4'b0001;
    step();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'b0001);
    chk("single_data", 32'(out[3:0]), 32'b0001);
    step();
    chk("single_empty", 32'(out_valid), 32'd0);
    // backpressure on slot 2
    out_ready = '0;
    in_valid = 1'b1; sel = 2'd2; in_data = 4'b0101;
    step();
    in_data = 4'b1010;
    chk("bp_full", 32'(out_valid[2]), 32'd1);
    chk("bp_blocked", 32'(in_ready), 32'd0);
    repeat (3) step();
    chk("bp_still_blocked", 32'(in_ready), 32'd0);
    chk("bp_hold", 32'(out[11:8]), 32'b0101);
    out_ready[2] = 1'b1;
    #1;
    chk("bp_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; out_ready = '0;
    chk("bp_second", 32'(out[11:8]), 32'b1010);
    out_ready = '1;
    step();
    // simultaneous drain and load on slot 3
    out_ready = '0;
    in_valid = 1'b1; sel = 2'd3; in_data = 4'b1000;
    step();
    out_ready[3] = 1'b1; in_data = 4'b0001;
    #1;
    chk("sim_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; out_ready[3] = 1'b0;
    chk("sim_full", 32'(out_valid[3]), 32'd1);
    chk("sim_data", 32'(out[15:12]), 32'b0001);
    out_ready = '1;
    step();
    // slot 1 stalled while others stream
    out_ready = 4'b1101;
    in_valid = 1'b1; sel = 2'd1; in_data = 4'b0110;
    step();
    for (int i = 0; i < 9; i++) begin
      sel = (i % 3 == 0) ? 2'd0 : (i % 3 == 1) ? 2'd2 : 2'd3;
      in_data = 4'(i + 3);
      #1;
      chk("ind_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    chk("ind_hold", 32'(out[7:4]), 32'b0110);
    chk("ind_valid", 32'(out_valid[1]), 32'd1);
    out_ready = '1;
    step();
    // out-of-range selects on the N=3 instance
    in_valid3 = 1'b1; sel3 = 2'd3;
    for (int i = 0; i < 260; i++) begin
      data3 = 4'(i);
      #1;
      chk("oor_ready", 32'(in_ready3), 32'd1);
      chk("oor_valid", 32'(out_valid3), 32'd0);
      chk("oor_cnt", 32'(drop_cnt3), (i > 255) ? 32'd255 : 32'(i));
      step();
    end
    in_valid3 = 1'b0;
    chk("oor_sat", 32'(drop_cnt3), 32'd255);
    // mid-operation reset with all slots full
    out_ready = '0;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1; sel = 2'(k); in_data = 4'(k + 9);
      step();
    end
    chk("mr_full", 32'(out_valid), 32'hF);
    sel = 2'd0; in_data = 4'hF; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_out", 32'(out), 32'd0);
    chk("mr_drop", 32'(drop_cnt3), 32'd0);
    step();
    chk("mr_noload", 32'(out_valid), 32'd0);
    // random traffic checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      in_data = 4'($urandom);
      out_ready = 4'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = '1;
    repeat (3) step();
    n = 0;
    for (int k = 0; k < N; k++) n += q[k].size();
    chk("drained", 32'(n), 32'd0);
    chk("final_valid", 32'(out_valid), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
